// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and state encodings for the UART frame receiver
// (byte receiver sub-module and frame parser).
package uart_frame_rx_pkg;

    localparam logic [7:0] HEADER = 8'hA5;
    localparam int         NUM_CH = 8;
    localparam int         ADDR_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HEAD,
        P_ADDR,
        P_DATA,
        P_SUM
    } parser_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / byte_ferr strobes at the stop-bit sample.
module uart_rx_byte
    import uart_frame_rx_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_ferr
);

    localparam int BIT_CYC = CLK_FRE * 1000000 / UART_RATE;
    localparam int CNT_W   = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             rx_fall;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       bit_idx;
    logic             half_hit;
    logic             bit_hit;

    // Synchronizer and edge-detect flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall  = rx_prev & ~rx_sync;
    assign half_hit = (cyc_cnt == HALF_LAST);
    assign bit_hit  = (cyc_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (rx_fall) state_nxt = START;
            START: if (half_hit) state_nxt = rx_sync ? IDLE : DATA;
            DATA:  if (bit_hit && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (bit_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_ferr  = 1'b0;
        if (state == STOP && bit_hit) begin
            byte_valid = rx_sync;
            byte_ferr  = ~rx_sync;
        end
    end

    // Cycle counter restarts on every state change and at each data-bit sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
        end else begin
            if (state != state_nxt || (state == DATA && bit_hit)) begin
                cyc_cnt <= '0;
            end else if (state != IDLE) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_hit) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && bit_hit) begin
            byte_data <= {rx_sync, byte_data[7:1]};
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: parses A5/addr/data/sum frames into eight DAC channel
// registers. Define FRAME_TIMEOUT_EN to abort stalled partial frames.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLK_FRE      = 50,
    parameter int UART_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rx,
    output logic [7:0][7:0] dac_data,
    output logic            frame_valid,
    output logic            frame_err
);

    localparam logic [7:0] CH_LIMIT = 8'(NUM_CH);

    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ferr;
    parser_state_t     pstate;
    parser_state_t     pstate_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        data_r;
    logic [7:0]        sum_calc;
    logic              ok_p0;
    logic              bad_p0;
    logic              tmo_hit;

    uart_rx_byte #(
        .CLK_FRE   (CLK_FRE),
        .UART_RATE (UART_RATE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ferr  (byte_ferr)
    );

`ifdef FRAME_TIMEOUT_EN
    localparam int BIT_CYC = CLK_FRE * 1000000 / UART_RATE;
    localparam int TMO_CYC = TIMEOUT_BITS * BIT_CYC;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (pstate == P_HEAD || byte_valid) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A byte event in the expiry cycle wins so the two pulses never coincide.
    assign tmo_hit = (pstate != P_HEAD) && (tmo_cnt == TMO_LAST) && !byte_valid && !byte_ferr;
`else
    assign tmo_hit = 1'b0;
`endif

    assign sum_calc = HEADER + 8'(addr_r) + data_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate <= P_HEAD;
        end else begin
            pstate <= pstate_nxt;
        end
    end

    always_comb begin
        ok_p0  = 1'b0;
        bad_p0 = 1'b0;
        case (pstate)
            P_HEAD: ;
            P_ADDR: bad_p0 = byte_ferr || (byte_valid && byte_data >= CH_LIMIT);
            P_DATA: bad_p0 = byte_ferr;
            P_SUM: begin
                if (byte_ferr) begin
                    bad_p0 = 1'b1;
                end else if (byte_valid) begin
                    ok_p0  = (byte_data == sum_calc);
                    bad_p0 = (byte_data != sum_calc);
                end
            end
            default: ;
        endcase
        if (tmo_hit) begin
            bad_p0 = 1'b1;
        end
    end

    always_comb begin
        pstate_nxt = pstate;
        if (ok_p0 || bad_p0) begin
            pstate_nxt = P_HEAD;
        end else if (byte_valid) begin
            case (pstate)
                P_HEAD:  if (byte_data == HEADER) pstate_nxt = P_ADDR;
                P_ADDR:  pstate_nxt = P_DATA;
                P_DATA:  pstate_nxt = P_SUM;
                default: pstate_nxt = P_HEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid && pstate == P_ADDR) begin
            addr_r <= byte_data[ADDR_W-1:0];
        end
        if (byte_valid && pstate == P_DATA) begin
            data_r <= byte_data;
        end
    end

    // p0 -> output: the channel write and both pulses land one cycle after the sum byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_data    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (ok_p0) begin
                dac_data[addr_r] <= data_r;
            end
            frame_valid <= ok_p0;
            frame_err   <= bad_p0;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: serial frames in, expected pulses queued
// at drive time and matched against frame_valid / frame_err as they appear.
`timescale 1ns/1ps
module tb_uart_frame_rx;

    localparam int CLK_FRE   = 5;
    localparam int UART_RATE = 115200;
    localparam int BIT       = CLK_FRE * 1000000 / UART_RATE;

    typedef struct {
        bit         is_err;
        int         ch;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            uart_rx = 1'b1;
    logic [7:0][7:0] dac_data;
    logic            frame_valid;
    logic            frame_err;

    exp_t       exp_q[$];
    logic [7:0] exp_dac[8];
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_frame_rx #(
        .CLK_FRE      (CLK_FRE),
        .UART_RATE    (UART_RATE),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .dac_data    (dac_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop;
        repeat (BIT) @(negedge clk);
        if (!stop) idle_bits(2);
    endtask

    task automatic push_ok(input int ch, input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.ch     = ch;
        e.data   = d;
        exp_q.push_back(e);
        exp_dac[ch] = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.ch     = 0;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {frame_err, frame_valid}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {frame_err, frame_valid}, e.is_err ? 2'b10 : 2'b01);
                if (!e.is_err) check("chan_write", dac_data[e.ch], e.data);
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) exp_dac[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_dac", dac_data, 64'h0);
        check("reset_valid", frame_valid, 1'b0);
        check("reset_err", frame_err, 1'b0);
        rst = 1'b0;
        idle_bits(2);

        // Good frame to channel 3
        send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h7E, 1'b1);
        push_ok(3, 8'h7E);
        send_byte(8'h26, 1'b1);
        idle_bits(2);

        // Bad checksum
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h10, 1'b1);
        push_err();
        send_byte(8'hB8, 1'b1);
        idle_bits(2);

        // Out-of-range address, trailing bytes discarded, then good frame to channel 0
        send_byte(8'hA5, 1'b1);
        push_err();
        send_byte(8'h09, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAE, 1'b1);
        idle_bits(2);
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1);
        push_ok(0, 8'hFF);
        send_byte(8'hA4, 1'b1);
        idle_bits(2);

        // 2 us glitch, framing error while idle, framing error mid-frame
        uart_rx = 1'b0;
        #2000;
        @(negedge clk);
        idle_bits(3);
        send_byte(8'h55, 1'b0);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h20, 1'b1);
        push_err();
        send_byte(8'h00, 1'b0);
        idle_bits(2);

        // Reset in the middle of the data byte
        send_byte(8'hA5, 1'b1); send_byte(8'h05, 1'b1);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            repeat (BIT) @(negedge clk);
        end
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_dac", dac_data, 64'h0);
        check("midreset_valid", frame_valid, 1'b0);
        check("midreset_err", frame_err, 1'b0);
        for (int i = 0; i < 8; i++) exp_dac[i] = 8'h00;
        rst = 1'b0;
        idle_bits(2);
        send_byte(8'hA5, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h33, 1'b1);
        push_ok(5, 8'h33);
        send_byte(8'hDD, 1'b1);
        idle_bits(2);

        // Partial frame then 200 us of idle line
        send_byte(8'hA5, 1'b1);
`ifdef FRAME_TIMEOUT_EN
        push_err();
`endif
        send_byte(8'h04, 1'b1);
        uart_rx = 1'b1;
        #200000;
        @(negedge clk);
        idle_bits(2);

        check("pending_expect", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) check($sformatf("final_dac%0d", i), dac_data[i], exp_dac[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
